// File: rtl/fpdiv_pkg.sv
// fpdiv_pkg: shared state type, flag indices, rounding modes and precision helpers for the fpdiv issue sequencer
package fpdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } fpdiv_issue_state_t;

    // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} exception vector
    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    localparam logic [2:0] RM_RN = 3'b000;
    localparam logic [2:0] RM_RZ = 3'b001;
    localparam logic [2:0] RM_RU = 3'b010;
    localparam logic [2:0] RM_RD = 3'b011;
    localparam logic [2:0] RM_RM = 3'b100;

    // fpdiv carries single-precision values in the upper half of its 64-bit lanes
    function automatic logic [63:0] sp_box(input logic [31:0] x);
        return {x, 32'h0};
    endfunction

    function automatic logic [63:0] sp_unbox(input logic [63:0] x);
        return {32'h0, x[63:32]};
    endfunction

endpackage

// File: rtl/fpdiv_pack.sv
// fpdiv_pack: combinational operand packing and result unpacking by precision
//
// Ports:
//   sp_i   1 = single precision, 0 = double precision
//   a_i    dividend as received (single precision in [31:0])
//   b_i    divisor, same packing as a_i
//   res_i  raw fpdiv result
//   op1_o  dividend in fpdiv lane format
//   op2_o  divisor in fpdiv lane format
//   res_o  result in response format (single precision zero-extended in [31:0])
module fpdiv_pack
    import fpdiv_pkg::*;
(
    input  logic        sp_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic [63:0] res_i,
    output logic [63:0] op1_o,
    output logic [63:0] op2_o,
    output logic [63:0] res_o
);

    assign op1_o = sp_i ? sp_box(a_i[31:0]) : a_i;
    assign op2_o = sp_i ? sp_box(b_i[31:0]) : b_i;
    assign res_o = sp_i ? sp_unbox(res_i) : res_i;

endmodule

// File: rtl/fpdiv_issue.sv
// fpdiv_issue: valid/ready request sequencer in front of the fpdiv divider
//
// Optional feature: define FPDIV_ISSUE_TIMEOUT_EN to add a WAIT-state watchdog
// that aborts a hung divide after TIMEOUT cycles (div_clr pulse, rsp_err=1).
//
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_a, req_b, req_rm, req_sp   operands, rounding mode, precision
//   rsp_valid/rsp_ready        response handshake
//   rsp_res, rsp_flags, rsp_err    result, {NV,DZ,OF,UF,NX}, watchdog abort
//   fflags, fflags_clr         sticky accumulated flags and their clear
//   div_op1, div_op2, div_rm, div_p, div_start, div_clr   drive to fpdiv
//   div_res, div_flags, div_done                           return from fpdiv
module fpdiv_issue
    import fpdiv_pkg::*;
#(
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [2:0]  req_rm,
    input  logic        req_sp,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_res,
    output logic [4:0]  rsp_flags,
    output logic        rsp_err,
    output logic [4:0]  fflags,
    input  logic        fflags_clr,
    output logic [63:0] div_op1,
    output logic [63:0] div_op2,
    output logic [2:0]  div_rm,
    output logic        div_p,
    output logic        div_start,
    output logic        div_clr,
    input  logic [63:0] div_res,
    input  logic [4:0]  div_flags,
    input  logic        div_done
);

    localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);

    fpdiv_issue_state_t state_q;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic [2:0]  rm_q;
    logic        sp_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [63:0] rsp_res_q;
    logic [4:0]  rsp_flags_q;
    logic        rsp_err_q;
    logic [4:0]  fflags_q;
    logic [4:0]  fflags_d;
    logic        div_start_q;
    logic        div_clr_q;
    logic [63:0] res_unpacked;
    logic        rsp_hs;
    logic        flags_hs;

`ifdef FPDIV_ISSUE_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wd_q;
    logic        wd_fire;
    assign wd_fire = wd_q == WD_LAST;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT > 0;
`endif

    fpdiv_pack u_pack (
        .sp_i  (sp_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .res_i (div_res),
        .op1_o (div_op1),
        .op2_o (div_op2),
        .res_o (res_unpacked)
    );

    assign rsp_hs   = state_q == RESP && rsp_ready;
    // An aborted operation never contributes flags, so its handshake behaves like no handshake
    assign flags_hs = rsp_hs && !rsp_err_q;

    // A clear coinciding with a handshake keeps the new operation's flags
    always_comb begin
        fflags_d = flags_hs ? (fflags_clr ? rsp_flags_q : fflags_q | rsp_flags_q) :
                   fflags_clr ? 5'd0 : fflags_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rm_q        <= '0;
            sp_q        <= 1'b0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            fflags_q    <= '0;
            div_start_q <= 1'b0;
            div_clr_q   <= 1'b0;
`ifdef FPDIV_ISSUE_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            div_clr_q <= 1'b0;
            fflags_q  <= fflags_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_q         <= req_a;
                        b_q         <= req_b;
                        rm_q        <= req_rm;
                        sp_q        <= req_sp;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        div_start_q <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    if (cnt_q == START_LAST) begin
                        div_start_q <= 1'b0;
                        state_q     <= WAIT;
`ifdef FPDIV_ISSUE_TIMEOUT_EN
                        wd_q        <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                // div_start is already registered low on entry, so the first
                // WAIT edge sees it low for a full cycle and done is trusted
                WAIT: begin
                    if (div_done) begin
                        rsp_res_q   <= res_unpacked;
                        rsp_flags_q <= div_flags;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
`ifdef FPDIV_ISSUE_TIMEOUT_EN
                    else if (wd_fire) begin
                        div_clr_q   <= 1'b1;
                        rsp_res_q   <= '0;
                        rsp_flags_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        wd_q <= wd_q + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign fflags    = fflags_q;
    assign div_rm    = rm_q;
    assign div_p     = sp_q;
    assign div_start = div_start_q;
    assign div_clr   = div_clr_q;

endmodule
